// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
//   state_e    : sequencer state encoding (idle / shifting / result cycle)
//   MIN_WIDTH  : smallest legal operand width
//   MAX_WIDTH  : largest legal operand width
package serial_adder_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    localparam int unsigned MIN_WIDTH = 2;
    localparam int unsigned MAX_WIDTH = 32;

endpackage

// File: rtl/serial_fa_cell.sv
// Single-bit full adder built only from 2-input NAND terms.
// Ports:
//   a_i, b_i, cin_i : addend bits and carry-in
//   s_o             : sum bit
//   cout_o          : carry-out
module serial_fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);

    logic n1, n2, n3, x_ab, n4, n5, n6;

    always_comb begin
        n1     = ~(a_i & b_i);
        n2     = ~(a_i & n1);
        n3     = ~(b_i & n1);
        x_ab   = ~(n2 & n3);      // a ^ b
        n4     = ~(x_ab & cin_i);
        n5     = ~(x_ab & n4);
        n6     = ~(cin_i & n4);
        s_o    = ~(n5 & n6);      // a ^ b ^ cin
        cout_o = ~(n1 & n4);      // a&b | (a^b)&cin
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell reused WIDTH times, LSB first.
// A start in idle captures a_i/b_i/cin_i; WIDTH shift cycles follow, then one
// result cycle with done_o high. sum_o/cout_o hold until the next result.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds ovf_o (signed overflow).
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start_i         : operation request, sampled only while idle
//   a_i, b_i, cin_i : operands and carry-in
//   busy_o          : high while shifting and during the result cycle
//   done_o          : one-cycle pulse, result valid
//   sum_o, cout_o   : result and final carry
//   ovf_o           : signed overflow (SERIAL_ADDER_OVF_EN only)
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("serial_adder: WIDTH out of range");
    end

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             cell_s, cell_c;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    serial_fa_cell u_cell (
        .a_i    (a_sh_q[0]),
        .b_i    (b_sh_q[0]),
        .cin_i  (carry_q),
        .s_o    (cell_s),
        .cout_o (cell_c)
    );

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        cnt_d    = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d    = ovf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    a_sh_d  = a_i;
                    b_sh_d  = b_i;
                    carry_d = cin_i;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                sum_sh_d = {cell_s, sum_sh_q[WIDTH-1:1]};
                carry_d  = cell_c;
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                    // Latch on entry to the result cycle so sum_o is already
                    // valid while done_o is high.
                    sum_d   = sum_sh_d;
                    cout_d  = cell_c;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q here is the carry into the MSB position.
                    ovf_d   = carry_q ^ cell_c;
`endif
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            cnt_q    <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy_o = (state_q != StIdle);
    assign done_o = (state_q == StDone);
    assign sum_o  = sum_q;
    assign cout_o = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf_o  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: an 8-bit instance for directed and
// random operations, a 4-bit instance for an exhaustive back-to-back sweep.
module tb_serial_adder;

    logic clk;
    logic rst_n;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf8, ovf4;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_done4  = -1;

    logic [9:0] exp8_q[$];
    logic [9:0] exp4_q[$];

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start8),
        .a_i     (a8),
        .b_i     (b8),
        .cin_i   (cin8),
        .busy_o  (busy8),
        .done_o  (done8),
        .sum_o   (sum8),
        .cout_o  (cout8)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf_o   (ovf8)
`endif
    );

    serial_adder #(.WIDTH(4)) u_dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start4),
        .a_i     (a4),
        .b_i     (b4),
        .cin_i   (cin4),
        .busy_o  (busy4),
        .done_o  (done4),
        .sum_o   (sum4),
        .cout_o  (cout4)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf_o   (ovf4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer addition, signed range test for overflow.
    function automatic logic [9:0] model(input int w, input int a, input int b, input int c);
        int full, half, res, sa, sb, ss;
        logic ovf;
        full = 1 << w;
        half = 1 << (w - 1);
        res  = (a + b + c) % (2 * full);
        sa   = (a >= half) ? a - full : a;
        sb   = (b >= half) ? b - full : b;
        ss   = sa + sb + c;
        ovf  = (ss > half - 1) || (ss < -half);
        return {ovf, res[8:0]};
    endfunction

    // Monitors: pop one expectation per done pulse.
    always @(negedge clk) begin
        logic [9:0] e;
        if (done8) begin
            if (exp8_q.size() == 0) begin
                check("done8_unexpected", 32'(done8), 32'd0);
            end else begin
                e = exp8_q.pop_front();
                check("result8", 32'({cout8, sum8}), 32'(e[8:0]));
`ifdef SERIAL_ADDER_OVF_EN
                check("ovf8", 32'(ovf8), 32'(e[9]));
`endif
            end
        end
    end

    always @(negedge clk) begin
        logic [9:0] e;
        if (done4) begin
            if (exp4_q.size() == 0) begin
                check("done4_unexpected", 32'(done4), 32'd0);
            end else begin
                e = exp4_q.pop_front();
                check("result4", 32'({cout4, sum4}), 32'(e[4:0]));
`ifdef SERIAL_ADDER_OVF_EN
                check("ovf4", 32'(ovf4), 32'(e[9]));
`endif
            end
            if (last_done4 >= 0) check("done4_spacing", 32'(cyc - last_done4), 32'd6);
            last_done4 = cyc;
        end
    end

    task automatic wait_idle8();
        int n = 0;
        while (busy8 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy8) check("idle8_timeout", 32'(busy8), 32'd0);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c);
        wait_idle8();
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        exp8_q.push_back(model(8, int'(a), int'(b), int'(c)));
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    initial begin
        int first_done, busy_cnt, done_cnt, d1, d2, n;
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_result", 32'({cout8, sum8}), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", 32'(ovf8), 32'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        op8(8'h5A, 8'h33, 1'b0);

        // Latency/busy profile, and sum must hold the previous result meanwhile.
        wait_idle8();
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; start8 = 1'b1;
        exp8_q.push_back(model(8, 0, 0, 0));
        @(posedge clk); #1;
        start8 = 1'b0;
        first_done = 0; busy_cnt = 0; done_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done8 && first_done == 0) first_done = k;
            busy_cnt += int'(busy8);
            done_cnt += int'(done8);
            if (k == 4) check("sum_hold", 32'({cout8, sum8}), 32'h08D);
        end
        check("done_latency", 32'(first_done), 32'd9);
        check("busy_cycles", 32'(busy_cnt), 32'd9);
        check("done_pulses", 32'(done_cnt), 32'd1);
        @(posedge clk); #1;

        op8(8'hFF, 8'h01, 1'b0);
        op8(8'h7F, 8'h01, 1'b0);
        op8(8'h80, 8'h80, 1'b1);

        // A start during busy is ignored; held high, it is taken in the idle cycle.
        wait_idle8();
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        exp8_q.push_back(model(8, 'h10, 'h20, 0));
        @(posedge clk); #1;
        start8 = 1'b0;
        d1 = 0; d2 = 0; done_cnt = 0;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (done8) begin
                done_cnt++;
                if (d1 == 0) d1 = k; else if (d2 == 0) d2 = k;
            end
            @(posedge clk); #1;
            if (k == 3) begin
                a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
                exp8_q.push_back(model(8, 'hAA, 'h55, 1));
            end
            if (k == 10) start8 = 1'b0;
        end
        check("ignored_first_done", 32'(d1), 32'd9);
        check("ignored_second_done", 32'(d2), 32'd19);
        check("ignored_done_count", 32'(done_cnt), 32'd2);

        // Reset in the middle of an operation.
        op8(8'h7F, 8'h01, 1'b0);
        wait_idle8();
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy8), 32'd0);
        check("midrst_done", 32'(done8), 32'd0);
        check("midrst_result", 32'({cout8, sum8}), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("midrst_ovf", 32'(ovf8), 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
        end
        op8(8'h12, 8'h34, 1'b1);

        for (int i = 0; i < 40; i++) begin
            op8(8'($urandom_range(255)), 8'($urandom_range(255)), 1'($urandom_range(1)));
        end

        // Exhaustive 4-bit sweep with start held high throughout.
        start4 = 1'b1;
        for (int i = 0; i < 512; i++) begin
            a4 = 4'(i[3:0]); b4 = 4'(i[7:4]); cin4 = i[8];
            exp4_q.push_back(model(4, i % 16, (i / 16) % 16, i / 256));
            @(posedge clk); #1;
            n = 0;
            while (busy4 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            if (busy4) begin
                check("idle4_timeout", 32'(busy4), 32'd0);
                break;
            end
        end
        start4 = 1'b0;

        n = 0;
        while ((exp8_q.size() != 0 || exp4_q.size() != 0) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain8", 32'(exp8_q.size()), 32'd0);
        check("drain4", 32'(exp4_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
